// File: rtl/pmem_resp_pkg.sv
// Shared definitions for the pmem_resp physical-memory responder:
// FSM state encoding, default base address, byte-lane count and the
// width of the latency down-counter.
package pmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

  localparam logic [63:0] PMEM_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int          PMEM_LANES     = 8;
  localparam int          PMEM_CNT_W     = 4;

endpackage

// File: rtl/pmem_resp_if.sv
// Request/response bus between the CPU (master) and pmem_resp (slave).
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high; valid, once raised, is held with stable payload until that
// edge, and ready may depend on state but never on the same-cycle valid.
interface pmem_resp_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wen;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_wmask;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pmem_resp_array.sv
// Byte-masked 64-bit word storage: synchronous write, combinational read
// of the addressed word (the caller registers the read result).
module pmem_resp_array
  import pmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PMEM_LANES-1:0] wmask,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);
  logic [63:0] mem [2**DEPTH_LOG2];

  // Write only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PMEM_LANES; i++) begin
      if (we && wmask[i]) begin
        mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[index];
endmodule

// File: rtl/pmem_resp.sv
// pmem_resp: single-outstanding memory responder with fixed LATENCY,
// backed by an internal byte-masked word array with a range check.
module pmem_resp
  import pmem_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = PMEM_BASE_ADDR,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  pmem_resp_if.slave  bus,
  output pmem_state_e state_o
);
  localparam logic [PMEM_CNT_W-1:0] CNT_LOAD = PMEM_CNT_W'(LATENCY - 1);

  pmem_state_e             state_q, state_d;
  logic [PMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [PMEM_LANES-1:0]   wmask_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic                    capture;
  logic                    access;

  // With LATENCY == 1 the access happens on the accepting edge, so the
  // live request fields are used instead of the not-yet-captured ones.
  logic                    acc_wen;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [PMEM_LANES-1:0]   acc_wmask;

  assign acc_wen   = (state_q == IDLE) ? bus.req_wen   : wen_q;
  assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign acc_wmask = (state_q == IDLE) ? bus.req_wmask : wmask_q;

  // Next-state, counter and access-strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and captured request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wen_q   <= bus.req_wen;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
    end
  end

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(64'd8 << DEPTH_LOG2);

  logic [ADDR_WIDTH-1:0] off;
  logic                  in_range;
  logic [63:0]           arr_rdata;

  // Addresses below BASE wrap to a huge offset, so one compare covers both ends.
  assign off      = acc_addr - BASE;
  assign in_range = (off < SPAN);

  pmem_resp_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (access && rst_n && acc_wen && in_range),
    .wmask (acc_wmask),
    .index (off[DEPTH_LOG2+2:3]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // Register the response on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else if (access) begin
      resp_err_q   <= !in_range;
      resp_rdata_q <= (in_range && !acc_wen) ? arr_rdata : '0;
    end
  end

  assign bus.req_ready  = rst_n && (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign state_o        = state_q;
endmodule
